// File: rtl/crc_stream_engine_if.sv
// rtl/crc_stream_engine_if.sv - payload beat stream in, framed CRC result out
interface crc_stream_engine_if #(
  parameter int DATA_W = 8,
  parameter int CRC_W  = 16
);
  localparam int BYTES   = DATA_W / 8;
  localparam int BYTES_W = $clog2(BYTES + 1);

  logic               In_Valid;
  logic               In_Ready;
  logic [DATA_W-1:0]  In_Data;
  logic               In_First;
  logic               In_Last;
  logic [BYTES_W-1:0] In_Bytes;
  logic               Crc_Valid;
  logic               Crc_Ready;
  logic [CRC_W-1:0]   Crc_Out;

  modport master (
    output In_Valid, In_Data, In_First, In_Last, In_Bytes, Crc_Ready,
    input  In_Ready, Crc_Valid, Crc_Out
  );

  modport slave (
    input  In_Valid, In_Data, In_First, In_Last, In_Bytes, Crc_Ready,
    output In_Ready, Crc_Valid, Crc_Out
  );
endinterface

// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - parametrised per-frame streaming CRC generator
// Whole beats fold into the accumulator in one cycle; the result is held until consumed.
module crc_stream_engine #(
  parameter int               CRC_W       = 16,
  parameter logic [CRC_W-1:0] POLY        = 16'h1021,
  parameter logic [CRC_W-1:0] INIT        = 16'hFFFF,
  parameter logic [CRC_W-1:0] XOR_OUT     = 16'h0000,
  parameter bit               REFLECT_IN  = 1'b0,
  parameter bit               REFLECT_OUT = 1'b0,
  parameter int               DATA_W      = 8
) (
  input  logic                Clk,
  input  logic                Rst_n,
  crc_stream_engine_if.slave  bus,
  output logic                Err_Restart,
  output logic [15:0]         Frame_Cnt
);
  localparam int BYTES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CRC_W-1:0] acc_q, acc_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [15:0]      cnt_d;
  logic             err_d;
  logic             accept;
  int               nbytes;
  logic [CRC_W-1:0] start_acc, beat_acc;

  // Lanes beyond nbytes are skipped; lane 0 is the most significant byte.
  function automatic logic [CRC_W-1:0] crc_beat(input logic [CRC_W-1:0] acc_in,
                                               input logic [DATA_W-1:0] data,
                                               input int n);
    logic [CRC_W-1:0] acc;
    logic [7:0]       b;
    logic             fb;
    acc = acc_in;
    for (int l = 0; l < BYTES; l++) begin
      b = data[DATA_W-1-8*l -: 8];
      if (l < n) begin
        for (int i = 0; i < 8; i++) begin
          fb  = acc[CRC_W-1] ^ (REFLECT_IN ? b[i] : b[7-i]);
          acc = {acc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
      end
    end
    return acc;
  endfunction

  function automatic logic [CRC_W-1:0] crc_final(input logic [CRC_W-1:0] a);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = REFLECT_OUT ? a[CRC_W-1-i] : a[i];
    return r ^ XOR_OUT;
  endfunction

  assign bus.In_Ready  = (state_q != DONE) || bus.Crc_Ready;
  assign bus.Crc_Valid = (state_q == DONE);
  assign bus.Crc_Out   = crc_q;

  always_comb begin
    accept    = bus.In_Valid && bus.In_Ready;
    nbytes    = (bus.In_Last && bus.In_Bytes != '0) ? int'(bus.In_Bytes) : BYTES;
    // A new frame (from IDLE, from a retiring DONE, or a restart) always seeds from INIT.
    start_acc = (state_q == BUSY && !bus.In_First) ? acc_q : INIT;
    beat_acc  = crc_beat(start_acc, bus.In_Data, nbytes);
    state_d   = state_q;
    acc_d     = acc_q;
    crc_d     = crc_q;
    cnt_d     = Frame_Cnt;
    err_d     = accept && bus.In_First && (state_q == BUSY);
    if (accept) begin
      if (bus.In_Last) begin
        state_d = DONE;
        acc_d   = INIT;
        crc_d   = crc_final(beat_acc);
        cnt_d   = Frame_Cnt + 16'd1;
      end else begin
        state_d = BUSY;
        acc_d   = beat_acc;
      end
    end else if (state_q == DONE && bus.Crc_Ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      acc_q       <= INIT;
      crc_q       <= '0;
      Err_Restart <= 1'b0;
      Frame_Cnt   <= 16'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      crc_q       <= crc_d;
      Err_Restart <= err_d;
      Frame_Cnt   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_crc_stream_engine.sv
// tb/tb_crc_stream_engine.sv - scoreboard bench for crc_stream_engine
// Three instances: CRC-16 defaults, CRC-32 over 32-bit beats, CRC-16 with zero init.
module tb_crc_stream_engine;
  typedef logic [7:0] bq_t[$];
  typedef struct packed { logic [31:0] crc; logic [15:0] cnt; } exp_t;
  typedef exp_t eq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  crc_stream_engine_if #(.DATA_W(8),  .CRC_W(16)) if0 ();
  crc_stream_engine_if #(.DATA_W(32), .CRC_W(32)) if1 ();
  crc_stream_engine_if #(.DATA_W(8),  .CRC_W(16)) if2 ();
  logic        err0, err1, err2;
  logic [15:0] cnt0, cnt1, cnt2;

  crc_stream_engine u0 (.Clk(clk), .Rst_n(rst_n), .bus(if0), .Err_Restart(err0), .Frame_Cnt(cnt0));
  crc_stream_engine #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF),
                      .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1), .DATA_W(32))
    u1 (.Clk(clk), .Rst_n(rst_n), .bus(if1), .Err_Restart(err1), .Frame_Cnt(cnt1));
  crc_stream_engine #(.INIT(16'h0000))
    u2 (.Clk(clk), .Rst_n(rst_n), .bus(if2), .Err_Restart(err2), .Frame_Cnt(cnt2));

  int  n_pass = 0;
  int  n_chk  = 0;
  bq_t msg [3];
  eq_t sb [3];
  bit  in_frame [3];
  int  cnt_exp [3];
  int  err_exp [3];
  int  err_seen [3];
  bit  rdy_rand = 1'b0;
  int  len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic bad(input string name);
    n_chk++;
    $display("FAIL %s: got timeout or unexpected event, expected none", name);
  endtask

  // Byte-at-a-time table-free forms: MSB-first CRC-16 and right-shifting reflected CRC-32.
  function automatic logic [31:0] ref_crc(input int w, input bq_t m);
    logic [31:0] c;
    if (w == 1) begin
      c = 32'hFFFFFFFF;
      foreach (m[i]) begin
        c = c ^ {24'h0, m[i]};
        repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
    end
    c = (w == 2) ? 32'h0 : 32'hFFFF;
    foreach (m[i]) begin
      c = c ^ {16'h0, m[i], 8'h0};
      repeat (8) c = c[15] ? (((c << 1) ^ 32'h1021) & 32'hFFFF) : ((c << 1) & 32'hFFFF);
    end
    return c;
  endfunction

  task automatic model_accept(input int w, input logic [31:0] d, input bit f, input bit l, input int nb);
    int   bytes;
    int   k;
    exp_t e;
    bytes = (w == 1) ? 4 : 1;
    if (f) begin
      if (in_frame[w]) err_exp[w]++;
      msg[w].delete();
    end
    k = (l && nb != 0 && nb <= bytes) ? nb : bytes;
    for (int i = 0; i < k; i++) msg[w].push_back(d[8*(bytes-1-i) +: 8]);
    if (l) begin
      cnt_exp[w] = (cnt_exp[w] + 1) % 65536;
      e.crc = ref_crc(w, msg[w]);
      e.cnt = 16'(cnt_exp[w]);
      sb[w].push_back(e);
      msg[w].delete();
      in_frame[w] = 1'b0;
    end else begin
      in_frame[w] = 1'b1;
    end
  endtask

  task automatic drive(input int w, input bit v, input logic [31:0] d, input bit f, input bit l, input int nb);
    case (w)
      0: begin if0.In_Valid = v; if0.In_Data = d[7:0]; if0.In_First = f; if0.In_Last = l; if0.In_Bytes = 1'(nb); end
      1: begin if1.In_Valid = v; if1.In_Data = d; if1.In_First = f; if1.In_Last = l; if1.In_Bytes = 3'(nb); end
      default: begin if2.In_Valid = v; if2.In_Data = d[7:0]; if2.In_First = f; if2.In_Last = l; if2.In_Bytes = 1'(nb); end
    endcase
  endtask

  task automatic set_rdy(input int w, input bit r);
    case (w)
      0: if0.Crc_Ready = r;
      1: if1.Crc_Ready = r;
      default: if2.Crc_Ready = r;
    endcase
  endtask

  function automatic bit in_ready(input int w);
    case (w)
      0: return if0.In_Ready;
      1: return if1.In_Ready;
      default: return if2.In_Ready;
    endcase
  endfunction

  task automatic idle(input int w);
    drive(w, 1'b0, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)));
  endtask

  task automatic tick(input int w);
    @(posedge clk);
    #1;
    if (rdy_rand) set_rdy(w, ($urandom_range(0, 2) != 0));
  endtask

  task automatic beat(input int w, input logic [31:0] d, input bit f, input bit l, input int nb, input int gap);
    int budget;
    bit acc;
    budget = 1000;
    acc = 1'b0;
    repeat (gap) tick(w);
    drive(w, 1'b1, d, f, l, nb);
    while (!acc) begin
      @(negedge clk);
      acc = in_ready(w);
      tick(w);
      budget--;
      if (!acc && budget == 0) begin
        bad("accept_timeout");
        break;
      end
    end
    idle(w);
    if (acc) model_accept(w, d, f, l, nb);
  endtask

  task automatic drain(input int w);
    int budget;
    budget = 200;
    set_rdy(w, 1'b1);
    while (sb[w].size() != 0 && budget > 0) begin
      tick(w);
      budget--;
    end
    if (sb[w].size() != 0) bad("drain_timeout");
    set_rdy(w, 1'b0);
  endtask

  task automatic retire(input int w, input logic [31:0] crc, input logic [15:0] cnt);
    exp_t e;
    if (sb[w].size() == 0) begin
      bad($sformatf("unexpected_result%0d", w));
      return;
    end
    e = sb[w].pop_front();
    chk($sformatf("crc_out%0d", w), crc, e.crc);
    chk($sformatf("frame_cnt%0d", w), {16'h0, cnt}, {16'h0, e.cnt});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (if0.Crc_Valid && if0.Crc_Ready) retire(0, {16'h0, if0.Crc_Out}, cnt0);
      if (if1.Crc_Valid && if1.Crc_Ready) retire(1, if1.Crc_Out, cnt1);
      if (if2.Crc_Valid && if2.Crc_Ready) retire(2, {16'h0, if2.Crc_Out}, cnt2);
      if (err0) err_seen[0]++;
      if (err1) err_seen[1]++;
      if (err2) err_seen[2]++;
    end
  end

  initial begin
    for (int w = 0; w < 3; w++) begin
      idle(w);
      set_rdy(w, 1'b0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_crc_valid", if0.Crc_Valid, 0);
    chk("rst_crc_out", if0.Crc_Out, 0);
    chk("rst_crc_out32", if1.Crc_Out, 0);
    chk("rst_err", err0, 0);
    chk("rst_frame_cnt", cnt0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", if0.In_Ready, 1);
    @(posedge clk);
    #1;

    // "123456789" as single-byte beats
    for (int i = 0; i < 9; i++) beat(0, 32'h31 + i, i == 0, i == 8, 1, 0);
    @(negedge clk);
    chk("t1_valid", if0.Crc_Valid, 1);
    chk("t1_crc", if0.Crc_Out, 32'h29B1);
    chk("t1_cnt", cnt0, 1);

    // Backpressure, then retire and new beat on the same edge
    @(posedge clk);
    #1;
    drive(0, 1'b1, 32'hA5, 1'b1, 1'b1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_in_ready_low", if0.In_Ready, 0);
      chk("t4_crc_hold", if0.Crc_Out, 32'h29B1);
      @(posedge clk);
      #1;
    end
    set_rdy(0, 1'b1);
    @(negedge clk);
    chk("t4_in_ready_retire", if0.In_Ready, 1);
    @(posedge clk);
    #1;
    set_rdy(0, 1'b0);
    idle(0);
    model_accept(0, 32'hA5, 1'b1, 1'b1, 1);
    @(negedge clk);
    chk("t4_valid_new", if0.Crc_Valid, 1);
    chk("t4_cnt", cnt0, 2);
    @(posedge clk);
    #1;
    drain(0);

    // CRC-32 over 32-bit beats, partial last beat
    beat(1, 32'h31323334, 1'b1, 1'b0, 0, 0);
    beat(1, 32'h35363738, 1'b0, 1'b0, 0, 1);
    beat(1, {8'h39, 24'($urandom)}, 1'b0, 1'b1, 1, 0);
    @(negedge clk);
    chk("t2_crc32", if1.Crc_Out, 32'hCBF43926);
    @(posedge clk);
    #1;
    drain(1);

    // Single-beat frame latency, zero init
    drive(2, 1'b1, 32'h01, 1'b1, 1'b1, 1);
    @(negedge clk);
    chk("t3_valid_before", if2.Crc_Valid, 0);
    tick(2);
    idle(2);
    model_accept(2, 32'h01, 1'b1, 1'b1, 1);
    @(negedge clk);
    chk("t3_valid", if2.Crc_Valid, 1);
    chk("t3_crc", if2.Crc_Out, 32'h1021);
    @(posedge clk);
    #1;
    drain(2);

    // Restart mid-frame
    for (int i = 0; i < 4; i++) beat(0, 32'h31 + i, i == 0, 1'b0, 1, 0);
    for (int i = 0; i < 9; i++) beat(0, 32'h31 + i, i == 0, i == 8, 1, 0);
    @(negedge clk);
    chk("t5_crc", if0.Crc_Out, 32'h29B1);
    chk("t5_err_pulses", err_seen[0], 1);
    @(posedge clk);
    #1;
    drain(0);

    // Randomised frames with gaps, restarts and result backpressure
    rdy_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        beat(0, $urandom, (i == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 11) == 0),
             i == len - 1, $urandom_range(0, 1), $urandom_range(0, 2));
    end
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++)
        beat(1, $urandom, (i == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0),
             i == len - 1, (i == len - 1) ? $urandom_range(0, 4) : $urandom_range(0, 7), $urandom_range(0, 2));
    end
    rdy_rand = 1'b0;
    drain(0);
    drain(1);

    // Reset mid-frame discards the partial frame
    beat(0, 32'h31, 1'b1, 1'b0, 1, 0);
    beat(0, 32'h32, 1'b0, 1'b0, 1, 0);
    rst_n = 1'b0;
    for (int w = 0; w < 3; w++) begin
      msg[w].delete();
      in_frame[w] = 1'b0;
      cnt_exp[w] = 0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) beat(0, 32'h31 + i, i == 0, i == 8, 1, 0);
    @(negedge clk);
    chk("t6_crc", if0.Crc_Out, 32'h29B1);
    chk("t6_cnt", cnt0, 1);
    @(posedge clk);
    #1;

    // Frame counter wrap: 65535 more back-to-back frames
    set_rdy(0, 1'b1);
    for (int i = 0; i < 65535; i++) beat(0, $urandom, 1'b1, 1'b1, 1, 0);
    @(negedge clk);
    chk("wrap_cnt", cnt0, 0);
    @(posedge clk);
    #1;
    drain(0);

    for (int w = 0; w < 3; w++) begin
      chk($sformatf("sb_empty%0d", w), sb[w].size(), 0);
      chk($sformatf("err_count%0d", w), err_seen[w], err_exp[w]);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
